// File: rtl/text_writer.sv
// Write stage for the 80x30 character buffer: consumes ASCII codes, keeps a text cursor and drives the buffer write port.
// Optional macro TW_LINE_CLEAR_EN clears each row that the cursor enters.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | ready for a code; printable/control codes handled in one cycle
// CLR_SCREEN | sweeping 0x00 over the whole screen, row-major
// CLR_LINE   | (TW_LINE_CLEAR_EN only) sweeping 0x00 over the row just entered
module text_writer #(
    parameter int H_TILES    = 80,
    parameter int V_TILES    = 30,
    parameter int COL_WIDTH  = 7,
    parameter int ROW_WIDTH  = 5,
    parameter int DATA_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  char_valid,
    output logic                  char_ready,
    input  logic [DATA_WIDTH-1:0] char_in,
    output logic                  wr_en,
    output logic [COL_WIDTH-1:0]  col_w,
    output logic [ROW_WIDTH-1:0]  row_w,
    output logic [DATA_WIDTH-1:0] din,
    output logic [COL_WIDTH-1:0]  cur_col,
    output logic [ROW_WIDTH-1:0]  cur_row,
    output logic                  busy
);

    localparam logic [COL_WIDTH-1:0]  COL_LAST   = COL_WIDTH'(H_TILES - 1);
    localparam logic [ROW_WIDTH-1:0]  ROW_LAST   = ROW_WIDTH'(V_TILES - 1);
    localparam logic [COL_WIDTH-1:0]  COL_ONE    = COL_WIDTH'(1);
    localparam logic [ROW_WIDTH-1:0]  ROW_ONE    = ROW_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] CODE_BS    = DATA_WIDTH'(8'h08);
    localparam logic [DATA_WIDTH-1:0] CODE_LF    = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CODE_FF    = DATA_WIDTH'(8'h0C);
    localparam logic [DATA_WIDTH-1:0] CODE_CR    = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] CODE_PRINT = DATA_WIDTH'(8'h20);

    typedef enum logic [1:0] {
        IDLE,
        CLR_SCREEN
`ifdef TW_LINE_CLEAR_EN
        , CLR_LINE
`endif
    } state_t;

    state_t                state_q,   state_d;
    logic                  wr_en_q,   wr_en_d;
    logic [COL_WIDTH-1:0]  col_w_q,   col_w_d;
    logic [ROW_WIDTH-1:0]  row_w_q,   row_w_d;
    logic [DATA_WIDTH-1:0] din_q,     din_d;
    logic [COL_WIDTH-1:0]  cur_col_q, cur_col_d;
    logic [ROW_WIDTH-1:0]  cur_row_q, cur_row_d;
    logic [ROW_WIDTH-1:0]  row_inc;

    assign row_inc = (cur_row_q == ROW_LAST) ? '0 : cur_row_q + ROW_ONE;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        col_w_d   = col_w_q;
        row_w_d   = row_w_q;
        din_d     = din_q;
        cur_col_d = cur_col_q;
        cur_row_d = cur_row_q;

        case (state_q)
            IDLE: begin
                if (char_valid) begin
                    if (char_in >= CODE_PRINT) begin
                        wr_en_d = 1'b1;
                        col_w_d = cur_col_q;
                        row_w_d = cur_row_q;
                        din_d   = char_in;
                        if (cur_col_q == COL_LAST) begin
                            cur_col_d = '0;
                            cur_row_d = row_inc;
`ifdef TW_LINE_CLEAR_EN
                            state_d   = CLR_LINE;
`endif
                        end else begin
                            cur_col_d = cur_col_q + COL_ONE;
                        end
                    end else begin
                        case (char_in)
                            CODE_CR: cur_col_d = '0;
                            CODE_LF: begin
                                cur_col_d = '0;
                                cur_row_d = row_inc;
`ifdef TW_LINE_CLEAR_EN
                                state_d   = CLR_LINE;
                                wr_en_d   = 1'b1;
                                col_w_d   = '0;
                                row_w_d   = row_inc;
                                din_d     = '0;
`endif
                            end
                            CODE_BS: begin
                                if (cur_col_q != '0) begin
                                    cur_col_d = cur_col_q - COL_ONE;
                                    wr_en_d   = 1'b1;
                                    col_w_d   = cur_col_q - COL_ONE;
                                    row_w_d   = cur_row_q;
                                    din_d     = '0;
                                end
                            end
                            CODE_FF: begin
                                state_d   = CLR_SCREEN;
                                wr_en_d   = 1'b1;
                                col_w_d   = '0;
                                row_w_d   = '0;
                                din_d     = '0;
                                cur_col_d = '0;
                                cur_row_d = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            // col_w/row_w double as the sweep counter; the first write was issued on entry.
            CLR_SCREEN: begin
                if (col_w_q == COL_LAST && row_w_q == ROW_LAST) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d = 1'b1;
                    din_d   = '0;
                    if (col_w_q == COL_LAST) begin
                        col_w_d = '0;
                        row_w_d = row_w_q + ROW_ONE;
                    end else begin
                        col_w_d = col_w_q + COL_ONE;
                    end
                end
            end

`ifdef TW_LINE_CLEAR_EN
            // Entry after a printable wrap leaves the char write on the old row, so start the sweep first.
            CLR_LINE: begin
                if (row_w_q != cur_row_q) begin
                    wr_en_d = 1'b1;
                    col_w_d = '0;
                    row_w_d = cur_row_q;
                    din_d   = '0;
                end else if (col_w_q == COL_LAST) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d = 1'b1;
                    col_w_d = col_w_q + COL_ONE;
                    din_d   = '0;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            col_w_q   <= '0;
            row_w_q   <= '0;
            din_q     <= '0;
            cur_col_q <= '0;
            cur_row_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            col_w_q   <= col_w_d;
            row_w_q   <= row_w_d;
            din_q     <= din_d;
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
        end
    end

    assign char_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign wr_en      = wr_en_q;
    assign col_w      = col_w_q;
    assign row_w      = row_w_q;
    assign din        = din_q;
    assign cur_col    = cur_col_q;
    assign cur_row    = cur_row_q;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer (default build): cursor motion, control codes, screen clear and reset abort.
module tb_text_writer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic [6:0] char_in = '0;
    logic       wr_en;
    logic [6:0] col_w;
    logic [4:0] row_w;
    logic [6:0] din;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #20 clk = ~clk;

    text_writer dut (
        .clk       (clk),
        .rstn      (rstn),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .char_in   (char_in),
        .wr_en     (wr_en),
        .col_w     (col_w),
        .row_w     (row_w),
        .din       (din),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a code, waits (bounded) for ready, and returns #1 after the transfer edge.
    task automatic send(input logic [6:0] c);
        int n;
        @(negedge clk);
        char_valid = 1'b1;
        char_in    = c;
        n = 0;
        while (char_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (char_ready !== 1'b1) check("send_ready_timeout", {31'b0, char_ready}, 32'd1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int bad;
        int cnt;
        int bad_din;
        int bad_rdy;
        int n;
        logic [6:0] last_c;
        logic [4:0] last_r;

        // Reset state
        #5;
        check("rst_wr_en",   {31'b0, wr_en}, 32'd0);
        check("rst_col_w",   {25'b0, col_w}, 32'd0);
        check("rst_row_w",   {27'b0, row_w}, 32'd0);
        check("rst_din",     {25'b0, din}, 32'd0);
        check("rst_cur_col", {25'b0, cur_col}, 32'd0);
        check("rst_cur_row", {27'b0, cur_row}, 32'd0);
        check("rst_busy",    {31'b0, busy}, 32'd0);
        check("rst_ready",   {31'b0, char_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;

        // Single 'A'
        send(7'h41);
        check("a_wr_en",   {31'b0, wr_en}, 32'd1);
        check("a_col_w",   {25'b0, col_w}, 32'd0);
        check("a_row_w",   {27'b0, row_w}, 32'd0);
        check("a_din",     {25'b0, din}, 32'h41);
        check("a_cur_col", {25'b0, cur_col}, 32'd1);
        @(posedge clk);
        #1;
        check("a_pulse_single", {31'b0, wr_en}, 32'd0);

        // Fill row 0 and wrap to row 1
        do_reset();
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            send(7'h41);
            if (wr_en !== 1'b1 || col_w !== 7'(i) || row_w !== 5'd0 || din !== 7'h41) bad++;
        end
        check("row0_fill_bad", bad, 0);
        check("row0_last_col", {25'b0, col_w}, 32'd79);
        check("row0_cur_row",  {27'b0, cur_row}, 32'd1);
        check("row0_cur_col",  {25'b0, cur_col}, 32'd0);

        // Bottom-right wrap to (0,0)
        do_reset();
        for (int i = 0; i < 29; i++) send(7'h0A);
        check("lf29_cur_row", {27'b0, cur_row}, 32'd29);
        for (int i = 0; i < 79; i++) send(7'h41);
        check("br_pre_col", {25'b0, cur_col}, 32'd79);
        send(7'h5A);
        check("br_wr_en",   {31'b0, wr_en}, 32'd1);
        check("br_col_w",   {25'b0, col_w}, 32'd79);
        check("br_row_w",   {27'b0, row_w}, 32'd29);
        check("br_cur_col", {25'b0, cur_col}, 32'd0);
        check("br_cur_row", {27'b0, cur_row}, 32'd0);

        // Backspace
        do_reset();
        send(7'h42);
        check("b_din", {25'b0, din}, 32'h42);
        send(7'h08);
        check("bs_wr_en",   {31'b0, wr_en}, 32'd1);
        check("bs_col_w",   {25'b0, col_w}, 32'd0);
        check("bs_din",     {25'b0, din}, 32'd0);
        check("bs_cur_col", {25'b0, cur_col}, 32'd0);
        send(7'h08);
        check("bs0_wr_en",   {31'b0, wr_en}, 32'd0);
        check("bs0_cur_col", {25'b0, cur_col}, 32'd0);
        check("bs0_cur_row", {27'b0, cur_row}, 32'd0);

        // CR / LF / BEL at (5,12)
        do_reset();
        for (int i = 0; i < 5; i++) send(7'h0A);
        for (int i = 0; i < 12; i++) send(7'h61);
        check("pos_cur_col", {25'b0, cur_col}, 32'd12);
        check("pos_cur_row", {27'b0, cur_row}, 32'd5);
        send(7'h0D);
        check("cr_wr_en",   {31'b0, wr_en}, 32'd0);
        check("cr_cur_col", {25'b0, cur_col}, 32'd0);
        check("cr_cur_row", {27'b0, cur_row}, 32'd5);
        send(7'h0A);
        check("lf_wr_en",   {31'b0, wr_en}, 32'd0);
        check("lf_cur_col", {25'b0, cur_col}, 32'd0);
        check("lf_cur_row", {27'b0, cur_row}, 32'd6);
        send(7'h07);
        check("bel_wr_en",   {31'b0, wr_en}, 32'd0);
        check("bel_cur_col", {25'b0, cur_col}, 32'd0);
        check("bel_cur_row", {27'b0, cur_row}, 32'd6);

        // Full screen clear with valid held high
        send(7'h41);
        @(negedge clk);
        check("ff_pre_ready", {31'b0, char_ready}, 32'd1);
        char_valid = 1'b1;
        char_in    = 7'h0C;
        @(posedge clk);
        #1;
        char_in = 7'h51;
        cnt = 0; bad_din = 0; bad_rdy = 0; n = 0;
        last_c = '0; last_r = '0;
        while (wr_en === 1'b1 && n < 3000) begin
            cnt++;
            if (din !== 7'h00) bad_din++;
            if (char_ready !== 1'b0 || busy !== 1'b1) bad_rdy++;
            last_c = col_w;
            last_r = row_w;
            @(posedge clk);
            #1;
            n++;
        end
        check("ff_write_count", cnt, 2400);
        check("ff_bad_din", bad_din, 0);
        check("ff_bad_ready", bad_rdy, 0);
        check("ff_last_col", {25'b0, last_c}, 32'd79);
        check("ff_last_row", {27'b0, last_r}, 32'd29);
        check("ff_end_ready", {31'b0, char_ready}, 32'd1);
        check("ff_end_busy",  {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        check("ff_next_wr_en", {31'b0, wr_en}, 32'd1);
        check("ff_next_col",   {25'b0, col_w}, 32'd0);
        check("ff_next_row",   {27'b0, row_w}, 32'd0);
        check("ff_next_din",   {25'b0, din}, 32'h51);

        // Reset in the middle of a sweep
        send(7'h0C);
        repeat (999) begin
            @(posedge clk);
            #1;
        end
        check("mid_wr_en_before", {31'b0, wr_en}, 32'd1);
        check("mid_col_before",   {25'b0, col_w}, 32'd39);
        check("mid_row_before",   {27'b0, row_w}, 32'd12);
        #3;
        rstn = 1'b0;
        #1;
        check("mid_wr_en",   {31'b0, wr_en}, 32'd0);
        check("mid_busy",    {31'b0, busy}, 32'd0);
        check("mid_cur_col", {25'b0, cur_col}, 32'd0);
        check("mid_cur_row", {27'b0, cur_row}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("mid_ready_after", {31'b0, char_ready}, 32'd1);
        send(7'h43);
        check("mid_next_col", {25'b0, col_w}, 32'd0);
        check("mid_next_din", {25'b0, din}, 32'h43);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
